// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, state encoding,
// default memory size and the address range check.
package lsu_pkg;

    localparam int ADDR_W        = 8;
    localparam int DATA_W        = 8;
    localparam int TAG_W         = 3;
    localparam int MEM_WORDS_DEF = 32;

    // Control FSM: IDLE accepts requests, READ strobes memory,
    // WAIT captures the registered read data, RESP holds the load result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // True when a word address falls inside the implemented data memory.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a, input int words);
        return (int'(a) < words);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundle of the execute-side request, writeback response, data-memory
// and status signals of the load/store unit.
interface load_store_unit_if #(
    parameter int SB_DEPTH = 2
);
    import lsu_pkg::*;

    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    // execute-stage request
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_rd;

    // writeback response
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [TAG_W-1:0]  resp_rd;
    logic              resp_fault;

    // data memory
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    // status
    logic [CNT_W-1:0]  sb_count;
    logic              err_flag;

    // LSU side
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_rd,
        output req_ready,
        output resp_valid, resp_data, resp_rd, resp_fault,
        input  resp_ready,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata,
        output sb_count, err_flag
    );

    // core / memory side
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_rd,
        input  req_ready,
        input  resp_valid, resp_data, resp_rd, resp_fault,
        output resp_ready,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata,
        input  sb_count, err_flag
    );

endinterface

// File: rtl/load_store_unit_store_buffer.sv
// Store buffer: small FIFO of pending stores with a lookup that returns
// the data of the youngest entry matching a given address.
module store_buffer
    import lsu_pkg::*;
#(
    parameter  int SB_DEPTH = 2,
    localparam int PW       = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1,
    localparam int CNT_W    = $clog2(SB_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_count,
    input  logic [ADDR_W-1:0] i_lk_addr,
    output logic              o_lk_hit,
    output logic [DATA_W-1:0] o_lk_data
);

    logic [ADDR_W-1:0] r_addr [SB_DEPTH];
    logic [DATA_W-1:0] r_data [SB_DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [PW-1:0]     w_idx;

    // Pointer and occupancy bookkeeping; reset discards every pending entry.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push)
                r_tail <= r_tail + PW'(1);
            if (i_pop)
                r_head <= r_head + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only meaningful under the count, so no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_addr[r_tail] <= i_push_addr;
            r_data[r_tail] <= i_push_data;
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest store.
    always_comb begin
        o_lk_hit  = 1'b0;
        o_lk_data = '0;
        w_idx     = r_head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if ((CNT_W'(i) < r_count) && (r_addr[w_idx] == i_lk_addr)) begin
                o_lk_hit  = 1'b1;
                o_lk_data = r_data[w_idx];
            end
        end
    end

    assign o_head_addr = r_addr[r_head];
    assign o_head_data = r_data[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: buffers stores and drains them to memory in order,
// serves loads by store-to-load forwarding, a memory read, or an
// out-of-range fault, and holds each load result until writeback takes it.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int SB_DEPTH  = 2,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              clk,
    input  logic              Reset,
    load_store_unit_if.slave  bus
);

    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    lsu_state_e        r_state;
    logic              r_resp_valid;
    logic              r_resp_fault;
    logic [DATA_W-1:0] r_resp_data;
    logic [TAG_W-1:0]  r_resp_rd;
    logic [ADDR_W-1:0] r_ld_addr;
    logic              r_err_flag;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_ready;
    logic              w_accept;
    logic              w_in_range;
    logic              w_push;
    logic              w_drain;
    logic              w_mem_read;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;
    logic [CNT_W-1:0]  w_sb_count;
    logic              w_lk_hit;
    logic [DATA_W-1:0] w_lk_data;

    assign w_in_range = addr_in_range(bus.req_addr, MEM_WORDS);
    // Held low while Reset is asserted so acceptance begins the cycle after release.
    assign w_ready    = !Reset && (r_state == IDLE) && (w_sb_count < CNT_W'(SB_DEPTH));
    assign w_accept   = bus.req_valid && w_ready;
    assign w_push     = w_accept && bus.req_write && w_in_range;
    // The memory port belongs to the load only while in READ; every other
    // cycle it retires the oldest buffered store.
    assign w_mem_read = (r_state == READ);
    assign w_drain    = !w_mem_read && (w_sb_count != '0);

    store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .clk         (clk),
        .Reset       (Reset),
        .i_push      (w_push),
        .i_push_addr (bus.req_addr),
        .i_push_data (bus.req_wdata),
        .i_pop       (w_drain),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_count     (w_sb_count),
        .i_lk_addr   (bus.req_addr),
        .o_lk_hit    (w_lk_hit),
        .o_lk_data   (w_lk_data)
    );

    // Control FSM with registered response and sticky error outputs.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_data  <= '0;
            r_resp_rd    <= '0;
            r_ld_addr    <= '0;
            r_err_flag   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (bus.req_write) begin
                            if (!w_in_range)
                                r_err_flag <= 1'b1;
                        end else begin
                            r_resp_rd <= bus.req_rd;
                            if (!w_in_range) begin
                                r_resp_data  <= '0;
                                r_resp_fault <= 1'b1;
                                r_resp_valid <= 1'b1;
                                r_state      <= RESP;
                            end else if (w_lk_hit) begin
                                r_resp_data  <= w_lk_data;
                                r_resp_fault <= 1'b0;
                                r_resp_valid <= 1'b1;
                                r_state      <= RESP;
                            end else begin
                                r_ld_addr <= bus.req_addr;
                                r_state   <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_resp_data  <= bus.mem_rdata;
                    r_resp_fault <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Remember the last address/data put on the memory port so it holds when idle.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_mem_read) begin
            r_mem_addr <= r_ld_addr;
        end else if (w_drain) begin
            r_mem_addr  <= w_head_addr;
            r_mem_wdata <= w_head_data;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_rd    = r_resp_rd;
    assign bus.resp_fault = r_resp_fault;
    assign bus.mem_read   = w_mem_read;
    assign bus.mem_write  = w_drain;
    assign bus.mem_addr   = w_mem_read ? r_ld_addr : (w_drain ? w_head_addr : r_mem_addr);
    assign bus.mem_wdata  = w_drain ? w_head_data : r_mem_wdata;
    assign bus.sb_count   = w_sb_count;
    assign bus.err_flag   = r_err_flag;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SB_DEPTH, 2, store-buffer entries (power of two, 2..4).
REQ-002 MEM_WORDS, 32, number of addressable data-memory words; addresses >= MEM_WORDS are out of range.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 Reset  in  1  reset Reset, asynchronous, active-high; clock clk.
REQ-005 req_valid  in  1  execute-stage request present.
REQ-006 req_ready  out  1  LSU accepts the request this cycle.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  8  word address.
REQ-009 req_wdata  in  8  store data.
REQ-010 req_rd  in  3  load destination register tag.
REQ-011 resp_valid  out  1  load result present.
REQ-012 resp_ready  in  1  writeback accepts the result.
REQ-013 resp_data / resp_rd / resp_fault  out  8/3/1  load data, tag, out-of-range flag.
REQ-014 mem_addr / mem_wdata  out  8/8  data-memory address and write data.
REQ-015 mem_read / mem_write  out  1/1  data-memory strobes; never both high in the same cycle.
REQ-016 mem_rdata  in  8  data-memory read data, registered by memory on the edge that samples mem_read.
REQ-017 sb_count  out  2  store-buffer occupancy; err_flag  out  1  sticky out-of-range-store flag.

Function
REQ-018 Transfer occurs on a posedge with valid and ready both high; req_ready = (state == IDLE) and (sb_count < SB_DEPTH).
REQ-019 Accepted in-range store enters store-buffer tail; no response is generated for stores.
REQ-020 Accepted out-of-range store is dropped, sets err_flag, and does not change sb_count.
REQ-021 Drain: in any cycle where state is not READ, a non-empty buffer drives its oldest entry on mem_addr/mem_wdata with mem_write=1 for exactly one cycle and pops it on that edge.
REQ-022 Simultaneous store accept and drain pop leaves sb_count unchanged; buffer drains in FIFO order.
REQ-023 Accepted out-of-range load: next state RESP with resp_data=0, resp_fault=1; no memory access.
REQ-024 Accepted in-range load whose address matches a buffered store: forward the youngest matching entry's data; next state RESP, resp_fault=0; no memory read.
REQ-025 Accepted in-range load with no match: IDLE -> READ (mem_read=1, mem_addr=load address, mem_write=0) -> WAIT (capture mem_rdata on the edge leaving WAIT) -> RESP.
REQ-026 Load latency: resp_valid high 1 cycle after acceptance for fault/forward, 3 cycles after acceptance for memory read.
REQ-027 RESP holds resp_data/resp_rd/resp_fault stable with resp_valid=1 until resp_ready; on handshake edge returns to IDLE.
REQ-028 Buffer continues draining while in WAIT or RESP; a store accepted and its address loaded back-to-back is always served by forwarding.
REQ-029 When idle with empty buffer, mem_read=mem_write=0 and mem_addr/mem_wdata hold last value.

Reset
REQ-030 On Reset: state IDLE, buffer emptied (pending stores discarded, never written), sb_count=0, err_flag=0.
REQ-031 On Reset: resp_valid=0, resp_data=0, resp_rd=0, resp_fault=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0; req_ready rises in the first cycle after Reset deasserts.

Structure
REQ-032 Package lsu_pkg holds state encoding (IDLE, READ, WAIT, RESP), MEM_WORDS default, data/address/tag widths.
REQ-033 Sub-module store_buffer: SB_DEPTH-entry FIFO with push, pop, count, and youngest-match address lookup.

Verification (memory preloaded word i = i for 0..15, word 17 = 8'hFF)
REQ-034 Load addr 5 tag 3, no stores -> mem_read one cycle at addr 5, resp_valid 3 cycles later, resp_data=5, resp_rd=3, resp_fault=0.
REQ-035 Store addr 4 data 8'hAA, then load addr 4 next cycle -> resp_data=8'hAA after 1 cycle, no mem_read; memory word 4 later written 8'hAA.
REQ-036 Load addr 40 -> resp_fault=1, resp_data=0, no memory strobe; store addr 40 -> err_flag=1, sb_count unchanged.
REQ-037 Three back-to-back stores (addr 1,2,3) with SB_DEPTH=2 -> req_ready drops when full, mem_write order 1,2,3, no loss.
REQ-038 Load addr 17 with resp_ready held low 5 cycles -> resp_data=8'hFF held stable, single response, then IDLE.
REQ-039 Assert Reset while in WAIT with 2 buffered stores -> all outputs zero, sb_count=0, discarded stores never appear on mem_write.
